muldiv_sequencer: RTL

Iterative multiply/divide unit with its own sequencing FSM. It sits beside the main multi-cycle controller, which issues one-cycle MultCtrl/DivCtrl start pulses with operands taken from the A/B registers. The block runs a radix-2 Booth multiply or a restoring divide, one iteration per clock. It then writes HI/LO and pulses done so the controller can leave its wait state.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_sequencer_if.sv | 30 +++
 rtl/muldiv_datapath.sv | 109 ++++++++++
 rtl/muldiv_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide sequencer.
// State encodings are plain localparams so legacy decoders can reuse them.
package muldiv_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CNT_W    = 6;
    // One Booth or restoring iteration per operand bit
    localparam int ITERS_PER_OP = DEF_WIDTH;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_MULT_RUN = 3'd1;
    localparam state_t ST_DIV_RUN  = 3'd2;
    localparam state_t ST_DIV_FIX  = 3'd3;
    localparam state_t ST_FINISH   = 3'd4;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Controller <-> multiply/divide unit bundle; is_unsigned exists only when
// MULDIV_UNSIGNED_EN is defined.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);

    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef MULDIV_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

`ifdef MULDIV_UNSIGNED_EN
    modport master (output mult_start, div_start, op_a, op_b, is_unsigned,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  mult_start, div_start, op_a, op_b, is_unsigned,
                    output busy, done, div_zero, hi, lo);
`else
    modport master (output mult_start, div_start, op_a, op_b,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  mult_start, div_start, op_a, op_b,
                    output busy, done, div_zero, hi, lo);
`endif

endinterface

// File: rtl/muldiv_datapath.sv
// Accumulator/shift datapath: radix-2 Booth (or shift-add when unsigned)
// multiply and restoring divide on magnitudes, plus the final sign fix.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_mul,
    input  logic             load_div,
    input  logic             step,
    input  logic             fix,
    input  logic             uns,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             uns_mode
);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Extra accumulator bit keeps MIN_INT Booth steps and unsigned carries exact
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH:0]   m_r;
    logic             qm1_r;
    logic             mul_r;
    logic             uns_r;
    logic             sa_r;
    logic             sb_r;

    logic [WIDTH:0]   addend_s;
    logic [WIDTH:0]   sum_s;
    logic             fill_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] diff_s;

    // Per-iteration arithmetic for both the multiply and the divide step
    always_comb begin
        addend_s = '0;
        if (uns_r) begin
            addend_s = q_r[0] ? m_r : '0;
        end else begin
            case ({q_r[0], qm1_r})
                2'b01:   addend_s = m_r;
                2'b10:   addend_s = -m_r;
                default: addend_s = '0;
            endcase
        end
        sum_s     = acc_r + addend_s;
        fill_s    = uns_r ? 1'b0 : sum_s[WIDTH];
        shifted_s = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
        diff_s    = {1'b0, shifted_s} - {1'b0, m_r};
    end

    // Operand load, iteration and sign-fix registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r <= '0;
            q_r   <= '0;
            m_r   <= '0;
            qm1_r <= 1'b0;
            mul_r <= 1'b0;
            uns_r <= 1'b0;
            sa_r  <= 1'b0;
            sb_r  <= 1'b0;
        end else if (load_mul) begin
            acc_r <= '0;
            q_r   <= op_b;
            m_r   <= {(op_a[WIDTH-1] & ~uns), op_a};
            qm1_r <= 1'b0;
            mul_r <= 1'b1;
            uns_r <= uns;
            sa_r  <= 1'b0;
            sb_r  <= 1'b0;
        end else if (load_div) begin
            acc_r <= '0;
            q_r   <= uns ? op_a : magnitude(op_a);
            m_r   <= {1'b0, (uns ? op_b : magnitude(op_b))};
            qm1_r <= 1'b0;
            mul_r <= 1'b0;
            uns_r <= uns;
            sa_r  <= op_a[WIDTH-1] & ~uns;
            sb_r  <= op_b[WIDTH-1] & ~uns;
        end else if (step) begin
            if (mul_r) begin
                {acc_r, q_r, qm1_r} <= {fill_s, sum_s, q_r};
            end else if (diff_s[WIDTH+1]) begin
                acc_r <= shifted_s;
                q_r   <= {q_r[WIDTH-2:0], 1'b0};
            end else begin
                acc_r <= diff_s[WIDTH:0];
                q_r   <= {q_r[WIDTH-2:0], 1'b1};
            end
        end else if (fix) begin
            q_r   <= (sa_r ^ sb_r) ? -q_r : q_r;
            acc_r <= sa_r ? -acc_r : acc_r;
        end
    end

    assign res_hi   = acc_r[WIDTH-1:0];
    assign res_lo   = q_r;
    assign uns_mode = uns_r;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: FSM, iteration counter and HI/LO result registers.
// Optional MULDIV_UNSIGNED_EN adds is_unsigned for MULTU/DIVU.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic              clock,
    input logic              reset,
    muldiv_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             accept_s;
    logic             uns_s;
    logic             uns_mode_s;
    logic             load_mul_s;
    logic             load_div_s;
    logic             step_s;
    logic             fix_s;
    logic [WIDTH-1:0] dp_hi_s;
    logic [WIDTH-1:0] dp_lo_s;

`ifdef MULDIV_UNSIGNED_EN
    assign uns_s = bus.is_unsigned;
`else
    assign uns_s = 1'b0;
`endif

    assign accept_s = (state_r == ST_IDLE) && (bus.mult_start || bus.div_start);

    // Next state, counter and datapath controls
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        load_mul_s = 1'b0;
        load_div_s = 1'b0;
        step_s     = 1'b0;
        fix_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                count_nx_s = '0;
                if (bus.mult_start) begin
                    state_nx_s = ST_MULT_RUN;
                    load_mul_s = 1'b1;
                end else if (bus.div_start) begin
                    if (bus.op_b == '0) begin
                        state_nx_s = ST_FINISH;
                    end else begin
                        state_nx_s = ST_DIV_RUN;
                        load_div_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MULT_RUN, ST_DIV_RUN: begin
                step_s = 1'b1;
                if (count_r == LAST_CNT) begin
                    count_nx_s = '0;
                    if (state_r == ST_MULT_RUN || uns_mode_s) begin
                        state_nx_s = ST_FINISH;
                    end else begin
                        state_nx_s = ST_DIV_FIX;
                    end
                end else begin
                    count_nx_s = count_r + CNT_W'(1);
                end
            end
            ST_DIV_FIX: begin
                fix_s      = 1'b1;
                state_nx_s = ST_FINISH;
            end
            ST_FINISH: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // FSM, status flags and HI/LO result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            count_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
        end else begin
            state_r <= state_nx_s;
            count_r <= count_nx_s;
            done_r  <= (state_r == ST_FINISH);
            if (accept_s) begin
                busy_r     <= 1'b1;
                div_zero_r <= ~bus.mult_start & (bus.op_b == '0);
            end else if (state_r == ST_FINISH) begin
                busy_r <= 1'b0;
            end
            // A divide by zero leaves the previous HI/LO untouched
            if (state_r == ST_FINISH && !div_zero_r) begin
                hi_r <= dp_hi_s;
                lo_r <= dp_lo_s;
            end
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .load_mul (load_mul_s),
        .load_div (load_div_s),
        .step     (step_s),
        .fix      (fix_s),
        .uns      (uns_s),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .res_hi   (dp_hi_s),
        .res_lo   (dp_lo_s),
        .uns_mode (uns_mode_s)
    );

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;

endmodule
